// File: rtl/ccr_stack.sv
// ccr_stack: condition-code register with a LIFO save stack for interrupt entry/exit.
// Latency: 1 cycle. ccr_out, depth_cnt and the error flags are registered; full/empty decode depth_cnt.
// Backpressure: none. A push when full or a pop when empty leaves the stack unchanged and still merges the CCR.
//
// Ports:
//   clk, rst                 single clock, asynchronous active-high reset
//   flags_in/flag_en/flag_mask  ALU flag update (per-bit select, gated by flag_en)
//   set_mask / clr_mask      per-bit force-to-1 / force-to-0 (clear beats set beats ALU)
//   push / pop               save CCR to the stack / restore CCR from the stack top
//   err_clr                  clears the sticky ovf_err / udf_err flags
//   ccr_out, depth_cnt       registered CCR and number of occupied stack slots
//   full, empty              decoded from depth_cnt
//   ovf_err, udf_err         sticky push-on-full / pop-on-empty indications
//
// Build option: define CCR_STACK_ERR_EN to implement the sticky error flags.
// Without it ovf_err/udf_err are tied low and err_clr is ignored.

module ccr_stack #(
  parameter int FLAG_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [FLAG_W-1:0]          flags_in,
  input  logic                       flag_en,
  input  logic [FLAG_W-1:0]          flag_mask,
  input  logic [FLAG_W-1:0]          set_mask,
  input  logic [FLAG_W-1:0]          clr_mask,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       err_clr,
  output logic [FLAG_W-1:0]          ccr_out,
  output logic [$clog2(DEPTH+1)-1:0] depth_cnt,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf_err,
  output logic                       udf_err
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  // Architectural state
  logic [FLAG_W-1:0] ccr_q, ccr_d;
  logic [CNT_W-1:0]  depth_q, depth_d;

  // Save slots carry no reset: nothing reads a slot before it is written,
  // because reads only happen when depth_q says the slot is occupied.
  logic [FLAG_W-1:0] stack_q [DEPTH];

  // Flag merge: ALU first, then set, then clear, so clear has the final say.
  logic [FLAG_W-1:0] alu_sel;
  logic [FLAG_W-1:0] merged;

  assign alu_sel = flag_mask & {FLAG_W{flag_en}};
  assign merged  = (((ccr_q & ~alu_sel) | (flags_in & alu_sel)) | set_mask) & ~clr_mask;

  // Stack occupancy decode
  logic is_full, is_empty;

  assign is_full  = (depth_q == DEPTH_C);
  assign is_empty = (depth_q == '0);

  // Operation decode. Push+pop on an empty stack degenerates to a plain
  // pop-on-empty; push+pop on a full stack is a legal swap.
  logic do_push, do_pop, do_swap;

  assign do_push = push & ~pop & ~is_full;
  assign do_pop  = pop & ~push & ~is_empty;
  assign do_swap = push & pop & ~is_empty;

  // Slot addressing: a push writes the first free slot, a swap rewrites the top.
  logic [IDX_W-1:0]  top_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic              slot_we;
  logic [FLAG_W-1:0] top_val;

  assign top_idx = IDX_W'(depth_q - ONE_C);
  assign wr_idx  = do_swap ? top_idx : IDX_W'(depth_q);
  assign slot_we = do_push | do_swap;
  assign top_val = stack_q[top_idx];

  // Next-state logic
  always_comb begin
    ccr_d   = merged;
    depth_d = depth_q;
    if (do_pop) begin
      // A restore overrides any same-cycle ALU/set/clear activity.
      ccr_d   = top_val;
      depth_d = depth_q - ONE_C;
    end else if (do_swap) begin
      ccr_d   = top_val;
    end else if (do_push) begin
      depth_d = depth_q + ONE_C;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ccr_q   <= '0;
      depth_q <= '0;
    end else begin
      ccr_q   <= ccr_d;
      depth_q <= depth_d;
    end
  end

  // Slot write is suppressed while reset is held so an operation that
  // collides with reset leaves no trace.
  always_ff @(posedge clk) begin
    if (!rst && slot_we) begin
      stack_q[wr_idx] <= merged;
    end
  end

`ifdef CCR_STACK_ERR_EN
  // Sticky error flags. A new event in the same cycle as err_clr wins,
  // so an error is never lost to a coincident clear.
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;
  logic ovf_evt, udf_evt;

  assign ovf_evt = push & ~pop & is_full;
  assign udf_evt = pop & is_empty;

  assign ovf_d = ovf_evt | (ovf_q & ~err_clr);
  assign udf_d = udf_evt | (udf_q & ~err_clr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf_err = ovf_q;
  assign udf_err = udf_q;
`else
  logic unused_err_clr;

  assign unused_err_clr = err_clr;
  assign ovf_err        = 1'b0;
  assign udf_err        = 1'b0;
`endif

  // Outputs
  assign ccr_out   = ccr_q;
  assign depth_cnt = depth_q;
  assign full      = is_full;
  assign empty     = is_empty;

endmodule

// File: tb/tb_ccr_stack.sv
// tb_ccr_stack: directed plus randomized check of ccr_stack against a queue-based model.
// Inputs change on the falling edge; outputs are compared on every falling edge.

module tb_ccr_stack;

  localparam int FLAG_W = 4;
  localparam int DEPTH  = 4;
`ifdef CCR_STACK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic [FLAG_W-1:0] flags_in;
  logic              flag_en;
  logic [FLAG_W-1:0] flag_mask;
  logic [FLAG_W-1:0] set_mask;
  logic [FLAG_W-1:0] clr_mask;
  logic              push;
  logic              pop;
  logic              err_clr;
  logic [FLAG_W-1:0] ccr_out;
  logic [2:0]        depth_cnt;
  logic              full;
  logic              empty;
  logic              ovf_err;
  logic              udf_err;

  int n_checks;
  int n_fail;
  bit chk_en;

  // Reference model state
  logic [FLAG_W-1:0] m_ccr;
  logic [FLAG_W-1:0] m_stack[$];
  bit                m_ovf;
  bit                m_udf;

  ccr_stack #(.FLAG_W(FLAG_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flags_in  (flags_in),
    .flag_en   (flag_en),
    .flag_mask (flag_mask),
    .set_mask  (set_mask),
    .clr_mask  (clr_mask),
    .push      (push),
    .pop       (pop),
    .err_clr   (err_clr),
    .ccr_out   (ccr_out),
    .depth_cnt (depth_cnt),
    .full      (full),
    .empty     (empty),
    .ovf_err   (ovf_err),
    .udf_err   (udf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: apply one clock edge of behaviour using plain queue operations.
  initial begin : model
    logic [FLAG_W-1:0] sel;
    logic [FLAG_W-1:0] mrg;
    logic [FLAG_W-1:0] t;
    bit ovf_ev, udf_ev;
    m_ccr = '0;
    m_ovf = 0;
    m_udf = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_ccr = '0;
        m_stack.delete();
        m_ovf = 0;
        m_udf = 0;
      end else begin
        sel = flag_en ? flag_mask : '0;
        mrg = (m_ccr & ~sel) | (flags_in & sel);
        mrg = mrg | set_mask;
        mrg = mrg & ~clr_mask;
        ovf_ev = 0;
        udf_ev = 0;
        if (push && !pop) begin
          if (m_stack.size() < DEPTH) m_stack.push_back(mrg);
          else ovf_ev = 1;
          m_ccr = mrg;
        end else if (pop && !push) begin
          if (m_stack.size() > 0) m_ccr = m_stack.pop_back();
          else begin udf_ev = 1; m_ccr = mrg; end
        end else if (push && pop) begin
          if (m_stack.size() > 0) begin
            t = m_stack[m_stack.size()-1];
            m_stack[m_stack.size()-1] = mrg;
            m_ccr = t;
          end else begin
            udf_ev = 1;
            m_ccr = mrg;
          end
        end else begin
          m_ccr = mrg;
        end
        if (ERR_EN) begin
          m_ovf = ovf_ev || (m_ovf && !err_clr);
          m_udf = udf_ev || (m_udf && !err_clr);
        end
      end
    end
  end

  // Compare process: every falling edge once checking is enabled.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("ccr_out",   32'(ccr_out),   32'(m_ccr));
        chk("depth_cnt", 32'(depth_cnt), 32'(m_stack.size()));
        chk("full",      32'(full),      32'(m_stack.size() == DEPTH));
        chk("empty",     32'(empty),     32'(m_stack.size() == 0));
        chk("ovf_err",   32'(ovf_err),   32'(m_ovf));
        chk("udf_err",   32'(udf_err),   32'(m_udf));
      end
    end
  end

  task automatic idle();
    flags_in  = '0;
    flag_en   = 0;
    flag_mask = '0;
    set_mask  = '0;
    clr_mask  = '0;
    push      = 0;
    pop       = 0;
    err_clr   = 0;
  endtask

  // Called at a falling edge; applies one cycle of inputs and returns at the next falling edge.
  task automatic drive(input bit fen, input logic [3:0] fmask, input logic [3:0] fin,
                       input logic [3:0] setm, input logic [3:0] clrm,
                       input bit ph, input bit pp, input bit ec);
    flag_en   = fen;
    flag_mask = fmask;
    flags_in  = fin;
    set_mask  = setm;
    clr_mask  = clrm;
    push      = ph;
    pop       = pp;
    err_clr   = ec;
    @(negedge clk);
    idle();
  endtask

  initial begin : stim
    chk_en   = 0;
    n_checks = 0;
    n_fail   = 0;
    idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset ccr",   32'(ccr_out),   32'h0);
    chk("reset depth", 32'(depth_cnt), 32'h0);
    chk("reset empty", 32'(empty),     32'h1);
    chk("reset errs",  32'({ovf_err, udf_err}), 32'h0);
    chk_en = 1;

    // ALU merge under mask
    drive(1, 4'b0101, 4'b1111, 4'h0, 4'h0, 0, 0, 0);
    chk("alu mask merge", 32'(ccr_out), 32'h5);

    // Clear beats set beats ALU
    drive(0, 4'h0, 4'h0, 4'h0, 4'hF, 0, 0, 0);
    chk("clear all", 32'(ccr_out), 32'h0);
    drive(1, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 0, 0, 0);
    chk("clr over set bit2", 32'(ccr_out[2]), 32'h0);
    drive(1, 4'b0011, 4'b0001, 4'b1000, 4'b0000, 0, 0, 0);
    chk("set over alu", 32'(ccr_out), 32'h9);

    // Fill, overflow, drain
    for (int v = 1; v <= 4; v++) drive(1, 4'hF, 4'(v), 4'h0, 4'h0, 1, 0, 0);
    chk("full after 4", 32'(full), 32'h1);
    drive(1, 4'hF, 4'h5, 4'h0, 4'h0, 1, 0, 0);
    chk("ovf depth", 32'(depth_cnt), 32'h4);
    chk("ovf flag",  32'(ovf_err),   32'(ERR_EN));
    chk("ovf merge", 32'(ccr_out),   32'h5);
    for (int v = 4; v >= 1; v--) begin
      drive(0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 1, 0);
      chk("pop restore", 32'(ccr_out), 32'(v));
    end
    chk("drained empty", 32'(empty), 32'h1);
    drive(0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 1);
    chk("ovf cleared", 32'(ovf_err), 32'h0);

    // Underflow, clear, and clear coinciding with a new event
    drive(0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 1, 0);
    chk("udf flag",  32'(udf_err),   32'(ERR_EN));
    chk("udf depth", 32'(depth_cnt), 32'h0);
    chk("udf ccr",   32'(ccr_out),   32'h1);
    drive(0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 1);
    chk("udf cleared", 32'(udf_err), 32'h0);
    drive(0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1, 1);
    chk("udf vs clr", 32'(udf_err), 32'(ERR_EN));
    chk("push+pop empty depth", 32'(depth_cnt), 32'h0);
    drive(0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 1);

    // Swap
    drive(1, 4'hF, 4'hA, 4'h0, 4'h0, 1, 0, 0);
    drive(1, 4'hF, 4'h5, 4'h0, 4'h0, 0, 0, 0);
    drive(0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1, 0);
    chk("swap ccr",   32'(ccr_out),   32'hA);
    chk("swap depth", 32'(depth_cnt), 32'h1);
    drive(0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 1, 0);
    chk("swap top", 32'(ccr_out), 32'h5);

    // Asynchronous reset in the middle of a push
    drive(1, 4'hF, 4'h3, 4'h0, 4'h0, 1, 0, 0);
    flag_en = 1; flag_mask = 4'hF; flags_in = 4'h7; push = 1;
    #2 rst = 1'b1;
    #1;
    chk("async rst ccr",   32'(ccr_out),   32'h0);
    chk("async rst depth", 32'(depth_cnt), 32'h0);
    @(negedge clk);
    idle();
    rst = 1'b0;
    @(negedge clk);
    chk("push discarded", 32'(depth_cnt), 32'h0);

    // Randomized phases alternating fill-biased and drain-biased traffic
    for (int i = 0; i < 3000; i++) begin
      int pp_push, pp_pop;
      pp_push = ((i / 40) % 2 == 0) ? 60 : 20;
      pp_pop  = ((i / 40) % 2 == 0) ? 20 : 60;
      flags_in  = 4'($urandom);
      flag_en   = ($urandom_range(0, 99) < 60);
      flag_mask = 4'($urandom);
      set_mask  = ($urandom_range(0, 99) < 15) ? 4'($urandom) : 4'h0;
      clr_mask  = ($urandom_range(0, 99) < 15) ? 4'($urandom) : 4'h0;
      push      = ($urandom_range(0, 99) < pp_push);
      pop       = ($urandom_range(0, 99) < pp_pop);
      err_clr   = ($urandom_range(0, 99) < 10);
      @(negedge clk);
    end
    idle();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ccr_stack.md
CCR_STACK -- requirements
Module: ccr_stack

Interface
REQ-001 SHALL have parameter FLAG_W, default 4, meaning number of condition flags (bit0=Z, bit1=N, bit2=C, bit3=V; higher bits are user flags).
REQ-002 SHALL have parameter DEPTH, default 4, meaning number of save slots in the flag stack (DEPTH >= 2).
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port flags_in  in  FLAG_W  flag values from ALU.
REQ-006 SHALL have port flag_en  in  1  enable ALU flag update.
REQ-007 SHALL have port flag_mask  in  FLAG_W  per-bit ALU update select.
REQ-008 SHALL have port set_mask  in  FLAG_W  per-bit force-to-1 (SETC-class instructions).
REQ-009 SHALL have port clr_mask  in  FLAG_W  per-bit force-to-0 (CLRC-class instructions).
REQ-010 SHALL have port push  in  1  save current CCR to stack (interrupt entry).
REQ-011 SHALL have port pop  in  1  restore CCR from stack top (RTI).
REQ-012 SHALL have port err_clr  in  1  clear sticky error flags.
REQ-013 SHALL have port ccr_out  out  FLAG_W  registered CCR value.
REQ-014 SHALL have port depth_cnt  out  clog2(DEPTH+1)  occupied stack slots.
REQ-015 SHALL have ports full, empty  out  1 each  combinational from depth_cnt (full = count==DEPTH, empty = count==0).
REQ-016 SHALL have ports ovf_err, udf_err  out  1 each  sticky push-on-full / pop-on-empty indications.

Function
REQ-017 SHALL compute the CCR update as a merge: bits with flag_en & flag_mask take flags_in, then set_mask bits are forced to 1, then clr_mask bits are forced to 0 (clear wins over set, set wins over ALU).
REQ-018 SHALL make ccr_out reflect any update one cycle after the input edge (latency 1); unaffected bits hold.
REQ-019 SHALL, on push without pop and not full, write the merged CCR of the same cycle into slot depth_cnt and increment depth_cnt, so a same-cycle ALU update is saved.
REQ-020 SHALL, on pop without push and not empty, load ccr_out from slot depth_cnt-1 and decrement depth_cnt; the restored value overrides flag_en, set_mask and clr_mask in that cycle.
REQ-021 SHALL, on push and pop together with stack not empty, swap: ccr_out takes the top slot, the top slot takes the merged CCR, and depth_cnt is unchanged.
REQ-022 SHALL treat push and pop together on an empty stack as a pop-on-empty (REQ-024); the push is discarded.
REQ-023 SHALL, on push when full, leave the stack and depth_cnt unchanged, still apply the CCR merge, and set ovf_err.
REQ-024 SHALL, on pop when empty, leave depth_cnt at 0, apply the CCR merge normally, and set udf_err.
REQ-025 SHALL hold ovf_err/udf_err until err_clr; if err_clr coincides with a new error event, the error flag SHALL remain set.
REQ-026 SHALL never wrap depth_cnt past 0 or DEPTH.

Reset
REQ-027 SHALL, while rst is high, force ccr_out=0, depth_cnt=0, ovf_err=0, udf_err=0 immediately, regardless of clk.
REQ-028 SHALL leave stack slot contents undefined after reset; no output may depend on them until they are written.
REQ-029 SHALL, when rst asserts during a push or pop, discard that operation.

Configuration
REQ-030 SHALL, with macro CCR_STACK_ERR_EN defined, implement sticky ovf_err/udf_err per REQ-023..025.
REQ-031 SHALL, without CCR_STACK_ERR_EN, tie ovf_err and udf_err to 0, ignore err_clr, and keep all other overflow/underflow behaviour (stack unchanged, CCR merge applied).

Verification
REQ-032 SHALL cover: reset, then flag_en=1, flag_mask=4'b0101, flags_in=4'b1111 -> ccr_out=4'b0101 on the next cycle.
REQ-033 SHALL cover: ccr_out=4'b0000, set_mask=4'b0100 together with clr_mask=4'b0100 and flag_en=1, flag_mask=4'b0100, flags_in=4'b0100 -> ccr_out bit2=0.
REQ-034 SHALL cover: push values 4'h1,4'h2,4'h3,4'h4 (DEPTH=4) -> full=1; a 5th push -> ovf_err=1 and depth_cnt=4; four pops restore 4'h4,4'h3,4'h2,4'h1.
REQ-035 SHALL cover: empty stack, pop -> udf_err=1, depth_cnt=0; err_clr -> udf_err=0 next cycle.
REQ-036 SHALL cover: depth_cnt=1, top=4'hA, ccr_out=4'h5, push+pop together -> ccr_out=4'hA, top=4'h5, depth_cnt=1.
REQ-037 SHALL cover: rst pulse between clock edges during a push -> ccr_out=0 and depth_cnt=0 immediately, with no edge required.
